// File: rtl/dice_result_bcd_if.sv
// Result-path bundle between the dice roller source and the BCD result stage.
// The master side drives the roll inputs and receives the display results.
interface dice_result_bcd_if #(
    parameter int TOTAL_W = 16
);
    logic               roll;
    logic [1:0]         die_select;
    logic [7:0]         rolled_number;
    logic [3:0]         bcd_hundreds;
    logic [3:0]         bcd_tens;
    logic [3:0]         bcd_ones;
    logic               result_valid;
    logic               range_error;
    logic               busy;
    logic               overrun;
    logic [7:0]         roll_count;
    logic [TOTAL_W-1:0] roll_total;

    modport master (
        output roll, die_select, rolled_number,
        input  bcd_hundreds, bcd_tens, bcd_ones, result_valid, range_error,
               busy, overrun, roll_count, roll_total
    );

    modport slave (
        input  roll, die_select, rolled_number,
        output bcd_hundreds, bcd_tens, bcd_ones, result_valid, range_error,
               busy, overrun, roll_count, roll_total
    );
endinterface

// File: rtl/dice_result_bcd.sv
// Captures a die result on the falling edge of roll, range-checks it, converts it to
// 3-digit BCD with a sequential double-dabble, and keeps saturating roll statistics.
module dice_result_bcd #(
    parameter int TOTAL_W   = 16,
    parameter bit SYNC_ROLL = 1'b0
) (
    input logic               clock,
    input logic               reset,
    dice_result_bcd_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t             state, state_nxt;
    logic               roll_s, roll_q, fall;
    logic [7:0]         val_q, shift_q;
    logic [11:0]        scratch_q, adj;
    logic [2:0]         iter_q;
    logic               err_q;
    logic [3:0]         hun_q, ten_q, one_q;
    logic               valid_q, range_q, overrun_q;
    logic [7:0]         count_q;
    logic [TOTAL_W-1:0] total_q;
    logic [TOTAL_W:0]   sum;

    generate
        if (SYNC_ROLL) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) sync_q <= '0;
                else        sync_q <= {sync_q[0], bus.roll};
            end
            assign roll_s = sync_q[1];
        end else begin : g_nosync
            assign roll_s = bus.roll;
        end
    endgenerate

    assign fall = roll_q & ~roll_s;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic range_bad(input logic [1:0] sel, input logic [7:0] v);
        logic [7:0] lim;
        case (sel)
            2'b00:   lim = 8'd4;
            2'b01:   lim = 8'd6;
            2'b10:   lim = 8'd8;
            default: return 1'b1;
        endcase
        return (v == 8'd0) || (v > lim);
    endfunction

    assign adj = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
    assign sum = {1'b0, total_q} + (TOTAL_W+1)'(val_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall) state_nxt = CONVERT;
            CONVERT: if (iter_q == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            roll_q    <= 1'b0;
            val_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            err_q     <= 1'b0;
            hun_q     <= '0;
            ten_q     <= '0;
            one_q     <= '0;
            valid_q   <= 1'b0;
            range_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
            total_q   <= '0;
        end else begin
            roll_q  <= roll_s;
            valid_q <= 1'b0;
            // A fall that arrives mid-conversion is dropped; only the flag records it.
            if (fall && state != IDLE) overrun_q <= 1'b1;
            case (state)
                IDLE: if (fall) begin
                    val_q     <= bus.rolled_number;
                    shift_q   <= bus.rolled_number;
                    scratch_q <= '0;
                    iter_q    <= '0;
                    err_q     <= range_bad(bus.die_select, bus.rolled_number);
                end
                CONVERT: begin
                    {scratch_q, shift_q} <= {adj, shift_q} << 1;
                    iter_q               <= iter_q + 3'd1;
                end
                DONE: begin
                    hun_q   <= scratch_q[11:8];
                    ten_q   <= scratch_q[7:4];
                    one_q   <= scratch_q[3:0];
                    range_q <= err_q;
                    valid_q <= 1'b1;
                    if (count_q != 8'hFF) count_q <= count_q + 8'd1;
                    if (!err_q) total_q <= sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.bcd_hundreds = hun_q;
    assign bus.bcd_tens     = ten_q;
    assign bus.bcd_ones     = one_q;
    assign bus.result_valid = valid_q;
    assign bus.range_error  = range_q;
    assign bus.busy         = (state != IDLE);
    assign bus.overrun      = overrun_q;
    assign bus.roll_count   = count_q;
    assign bus.roll_total   = total_q;
endmodule

// File: tb/tb_dice_result_bcd.sv
// Bench for dice_result_bcd: table of roll vectors plus hand-built overrun, reset-abort,
// saturation and synchronizer-latency sequences; results checked through a scoreboard queue.
module tb_dice_result_bcd;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       roll = 1'b0;
    logic [1:0] die_select = 2'b00;
    logic [7:0] rolled_number = 8'd0;

    always #5 clock = ~clock;

    dice_result_bcd_if #(.TOTAL_W(16)) bus();
    dice_result_bcd_if #(.TOTAL_W(8))  bus8();

    assign bus.roll           = roll;
    assign bus.die_select     = die_select;
    assign bus.rolled_number  = rolled_number;
    assign bus8.roll          = roll;
    assign bus8.die_select    = die_select;
    assign bus8.rolled_number = rolled_number;

    dice_result_bcd #(.TOTAL_W(16), .SYNC_ROLL(1'b0)) u_dut  (.clock(clock), .reset(reset), .bus(bus));
    dice_result_bcd #(.TOTAL_W(8),  .SYNC_ROLL(1'b1)) u_dut8 (.clock(clock), .reset(reset), .bus(bus8));

    typedef struct { int h; int t; int o; int err; int cnt; int tot; } exp_t;
    typedef struct { logic [1:0] sel; logic [7:0] val; int h; int t; int o; int err; } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[12];
    int   total = 0;
    int   bad = 0;
    int   m_cnt = 0;
    int   m_tot = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference counters follow the roll statistics rules; digits come from plain arithmetic.
    task automatic push_exp(input int v, input int err);
        exp_t e;
        if (m_cnt < 255) m_cnt++;
        if (err == 0) m_tot = (m_tot + v > 65535) ? 65535 : m_tot + v;
        e.h = v / 100; e.t = (v / 10) % 10; e.o = v % 10;
        e.err = err; e.cnt = m_cnt; e.tot = m_tot;
        sbq.push_back(e);
    endtask

    always @(negedge clock) begin
        if (reset && bus.result_valid) begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_result: got bcd %0d%0d%0d want none at %0t",
                         bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones, $time);
            end else begin
                mon_e = sbq.pop_front();
                check("bcd_hundreds", int'(bus.bcd_hundreds), mon_e.h);
                check("bcd_tens",     int'(bus.bcd_tens),     mon_e.t);
                check("bcd_ones",     int'(bus.bcd_ones),     mon_e.o);
                check("range_error",  int'(bus.range_error),  mon_e.err);
                check("roll_count",   int'(bus.roll_count),   mon_e.cnt);
                check("roll_total",   int'(bus.roll_total),   mon_e.tot);
            end
        end
    end

    task automatic fire(input logic [1:0] sel, input logic [7:0] v);
        @(negedge clock);
        die_select = sel; rolled_number = v; roll = 1'b1;
        @(negedge clock);
        roll = 1'b0;
    endtask

    // k counts negedges after the capture edge; result expected at k=9.
    task automatic wait_result(output int lat, output int busy_n);
        lat = -1; busy_n = 0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clock);
            busy_n += int'(bus.busy);
            if (bus.result_valid) begin lat = k; break; end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        m_cnt = 0; m_tot = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    int lat, bn, lat8, nval;

    initial begin
        vecs[0]  = '{2'b00,   3, 0, 0, 3, 0};
        vecs[1]  = '{2'b11,   5, 0, 0, 5, 1};
        vecs[2]  = '{2'b10, 255, 2, 5, 5, 1};
        vecs[3]  = '{2'b10,   0, 0, 0, 0, 1};
        vecs[4]  = '{2'b01,   6, 0, 0, 6, 0};
        vecs[5]  = '{2'b01,   7, 0, 0, 7, 1};
        vecs[6]  = '{2'b00,   4, 0, 0, 4, 0};
        vecs[7]  = '{2'b00,   5, 0, 0, 5, 1};
        vecs[8]  = '{2'b10,   8, 0, 0, 8, 0};
        vecs[9]  = '{2'b10, 123, 1, 2, 3, 1};
        vecs[10] = '{2'b10,  99, 0, 9, 9, 1};
        vecs[11] = '{2'b00,   1, 0, 0, 1, 0};

        repeat (3) @(negedge clock);
        check("reset_bcd", int'({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}), 0);
        check("reset_valid", int'(bus.result_valid), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_count", int'(bus.roll_count), 0);
        check("reset_total", int'(bus.roll_total), 0);
        check("reset_flags", int'({bus.range_error, bus.overrun}), 0);
        reset = 1'b1;

        // First roll: latency and busy window
        fire(2'b00, 8'd3);
        push_exp(3, 0);
        wait_result(lat, bn);
        check("latency", lat, 9);
        check("busy_cycles", bn, 9);

        foreach (vecs[i]) begin
            fire(vecs[i].sel, vecs[i].val);
            push_exp(vecs[i].h * 100 + vecs[i].t * 10 + vecs[i].o, vecs[i].err);
            wait_result(lat, bn);
            check("vec_latency", lat, 9);
            check("vec_digits", int'({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}),
                  (vecs[i].h << 8) | (vecs[i].t << 4) | vecs[i].o);
        end
        repeat (5) @(negedge clock);
        check("hold_ones", int'(bus.bcd_ones), 1);
        check("hold_range", int'(bus.range_error), 0);
        check("no_overrun_yet", int'(bus.overrun), 0);

        // Second fall during conversion is dropped and flagged
        fire(2'b00, 8'd2);
        push_exp(2, 0);
        @(negedge clock);
        roll = 1'b1; rolled_number = 8'd9;
        @(negedge clock);
        roll = 1'b0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (bus.result_valid) begin lat = k; break; end
        end
        check("overrun_result_seen", int'(lat >= 0), 1);
        check("overrun_set", int'(bus.overrun), 1);
        repeat (12) @(negedge clock);
        fire(2'b01, 8'd5);
        push_exp(5, 0);
        wait_result(lat, bn);
        check("overrun_sticky", int'(bus.overrun), 1);

        // Reset in the middle of a conversion
        fire(2'b10, 8'd7);
        repeat (4) @(negedge clock);
        check("busy_before_abort", int'(bus.busy), 1);
        reset = 1'b0;
        m_cnt = 0; m_tot = 0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_bcd", int'({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones}), 0);
        check("abort_count", int'(bus.roll_count), 0);
        check("abort_total", int'(bus.roll_total), 0);
        check("abort_flags", int'({bus.overrun, bus.range_error, bus.result_valid}), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        nval = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            nval += int'(bus.result_valid);
        end
        check("abort_no_valid", nval, 0);
        fire(2'b00, 8'd4);
        push_exp(4, 0);
        wait_result(lat, bn);
        check("post_abort_latency", lat, 9);
        check("post_abort_count", int'(bus.roll_count), 1);

        // Saturation: 300 d8 rolls of 8, spaced for the synchronized instance too
        do_reset();
        for (int i = 0; i < 300; i++) begin
            fire(2'b10, 8'd8);
            push_exp(8, 0);
            wait_result(lat, bn);
            if (lat < 0) check("sat_timeout", lat, 9);
            repeat (3) @(negedge clock);
        end
        check("sat_count", int'(bus.roll_count), 255);
        check("sat_total", int'(bus.roll_total), 2400);
        check("sat8_count", int'(bus8.roll_count), 255);
        check("sat8_total", int'(bus8.roll_total), 255);
        check("sat8_overrun", int'(bus8.overrun), 0);

        // Synchronized instance adds two cycles
        do_reset();
        fire(2'b00, 8'd2);
        push_exp(2, 0);
        lat = -1; lat8 = -1;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clock);
            if (bus.result_valid  && lat  < 0) lat  = k;
            if (bus8.result_valid && lat8 < 0) lat8 = k;
        end
        check("latency_nosync", lat, 9);
        check("latency_sync", lat8, 11);
        check("sync_bcd", int'({bus8.bcd_hundreds, bus8.bcd_tens, bus8.bcd_ones}), 2);
        check("sync_total", int'(bus8.roll_total), 2);

        check("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
